// File: rtl/issue_queue_pkg.sv
// ---------------------------------------------------------------------------
// issue_queue_pkg
// Shared types for the unified issue queue: the functional-unit type enum,
// the queue entry record and the default sizing constants.
// Optional feature macro used by the issue queue: IQ_AGE_SELECT_EN.
// ---------------------------------------------------------------------------
package issue_queue_pkg;

    localparam int IQ_SS        = 2;
    localparam int IQ_DEPTH     = 16;
    localparam int IQ_CDB_PORTS = 2;
    localparam int IQ_NUM_FU    = 3;
    localparam int IQ_PREG_W    = 6;
    localparam int IQ_ROB_W     = 5;
    localparam int IQ_PAYLOAD_W = 32;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_BR  = 2'd2
    } fu_type_t;

    typedef struct packed {
        fu_type_t                fu_type;
        logic [IQ_PREG_W-1:0]    prs1;
        logic [IQ_PREG_W-1:0]    prs2;
        logic                    rdy1;
        logic                    rdy2;
        logic [IQ_ROB_W-1:0]     rob_id;
        logic [IQ_PAYLOAD_W-1:0] payload;
    } iq_entry_t;

endpackage

// File: rtl/issue_queue_if.sv
// ---------------------------------------------------------------------------
// issue_queue_if
// Bundles dispatch, CDB snoop and issue signals of the issue queue.
//   master : dispatch/CDB/FU side (drives flush, dispatch_*, cdb_*, fu_ready)
//   slave  : the issue queue (drives dispatch_ready, issue_*, occupancy)
// Optional feature macro of the block using it: IQ_AGE_SELECT_EN.
// ---------------------------------------------------------------------------
interface issue_queue_if #(
    parameter int SS        = issue_queue_pkg::IQ_SS,
    parameter int DEPTH     = issue_queue_pkg::IQ_DEPTH,
    parameter int CDB_PORTS = issue_queue_pkg::IQ_CDB_PORTS,
    parameter int NUM_FU    = issue_queue_pkg::IQ_NUM_FU
) ();
    import issue_queue_pkg::*;

    logic                                      flush;
    logic [SS-1:0]                             dispatch_valid;
    iq_entry_t [SS-1:0]                        dispatch_entry;
    logic                                      dispatch_ready;
    logic [CDB_PORTS-1:0]                      cdb_valid;
    logic [CDB_PORTS-1:0][IQ_PREG_W-1:0]       cdb_preg;
    logic [NUM_FU-1:0]                         fu_ready;
    logic [NUM_FU-1:0]                         issue_valid;
    iq_entry_t [NUM_FU-1:0]                    issue_entry;
    logic [$clog2(DEPTH+1)-1:0]                occupancy;

    modport master (
        output flush, dispatch_valid, dispatch_entry, cdb_valid, cdb_preg, fu_ready,
        input  dispatch_ready, issue_valid, issue_entry, occupancy
    );

    modport slave (
        input  flush, dispatch_valid, dispatch_entry, cdb_valid, cdb_preg, fu_ready,
        output dispatch_ready, issue_valid, issue_entry, occupancy
    );

endinterface

// File: rtl/iq_select.sv
// ---------------------------------------------------------------------------
// iq_select
// Per-port priority picker for the issue queue.
//   req   : one request bit per queue slot
//   older : (IQ_AGE_SELECT_EN only) older[j][i] = slot j is older than slot i
//   grant : one-hot grant, zero when nothing requests
// IQ_AGE_SELECT_EN defined   -> grant the oldest requester.
// IQ_AGE_SELECT_EN undefined -> grant the lowest-index requester.
// ---------------------------------------------------------------------------
module iq_select #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]            req,
`ifdef IQ_AGE_SELECT_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
`endif
    output logic [DEPTH-1:0]            grant
);

`ifdef IQ_AGE_SELECT_EN
    // A requester wins when no other requester is older than it.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = req[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && req[j] && older[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end
`else
    // Fixed priority: the first requester from slot 0 upward wins.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && grant == '0) begin
                grant[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/issue_queue.sv
// ---------------------------------------------------------------------------
// issue_queue
// Unified issue queue between rename/dispatch and the functional units.
// Accepts up to SS instructions per cycle into any free slot, wakes operands
// by snooping every CDB port, and issues at most one ready instruction per
// FU port per cycle (port f serves fu_type f).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   iq       : issue_queue_if.slave (flush, dispatch, CDB, fu_ready, issue,
//              occupancy)
// Optional feature macro: IQ_AGE_SELECT_EN (age-matrix oldest-first select;
// otherwise lowest slot index wins).
// ---------------------------------------------------------------------------
module issue_queue #(
    parameter int SS        = issue_queue_pkg::IQ_SS,
    parameter int DEPTH     = issue_queue_pkg::IQ_DEPTH,
    parameter int CDB_PORTS = issue_queue_pkg::IQ_CDB_PORTS,
    parameter int NUM_FU    = issue_queue_pkg::IQ_NUM_FU
) (
    input  logic         clk,
    input  logic         rst,
    issue_queue_if.slave iq
);
    import issue_queue_pkg::*;

    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int LANE_W = (SS > 1) ? $clog2(SS) : 1;

    iq_entry_t [DEPTH-1:0]              slot_q, slot_d;
    logic [DEPTH-1:0]                   valid_q, valid_d;
    logic [NUM_FU-1:0]                  issue_valid_q, issue_valid_d;
    iq_entry_t [NUM_FU-1:0]             issue_entry_q, issue_entry_d;
    logic [OCC_W-1:0]                   occ;
    logic                               disp_ready;
    iq_entry_t [SS-1:0]                 disp_fixed;
    logic [DEPTH-1:0]                   wr_en;
    logic [DEPTH-1:0][LANE_W-1:0]       wr_lane;
    logic [NUM_FU-1:0][DEPTH-1:0]       req;
    logic [NUM_FU-1:0][DEPTH-1:0]       grant;
    logic [DEPTH-1:0]                   issued;
`ifdef IQ_AGE_SELECT_EN
    logic [DEPTH-1:0][DEPTH-1:0]        older_q, older_d;
`endif

    // Occupancy is the live count of valid slots, so it follows an
    // asynchronous reset immediately.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(valid_q[i]);
        end
    end

    // Only whole bundles are accepted, so we need room for all SS lanes.
    assign disp_ready        = (int'(occ) + SS) <= DEPTH;
    assign iq.dispatch_ready = disp_ready;
    assign iq.occupancy      = occ;
    assign iq.issue_valid    = issue_valid_q;
    assign iq.issue_entry    = issue_entry_q;

    // Dispatch bypass: operand tag 0 is always ready, and a broadcast in the
    // write cycle must not be lost for an entry that is not yet in a slot.
    always_comb begin
        for (int l = 0; l < SS; l++) begin
            disp_fixed[l] = iq.dispatch_entry[l];
            if (disp_fixed[l].prs1 == '0) disp_fixed[l].rdy1 = 1'b1;
            if (disp_fixed[l].prs2 == '0) disp_fixed[l].rdy2 = 1'b1;
            for (int k = 0; k < CDB_PORTS; k++) begin
                if (iq.cdb_valid[k] && iq.cdb_preg[k] == disp_fixed[l].prs1) disp_fixed[l].rdy1 = 1'b1;
                if (iq.cdb_valid[k] && iq.cdb_preg[k] == disp_fixed[l].prs2) disp_fixed[l].rdy2 = 1'b1;
            end
        end
    end

    // Slot allocation: the n-th valid lane (counting from lane 0) lands in
    // the n-th free slot counting from slot 0.
    always_comb begin
        int free_rank;
        int lane_rank;
        wr_en     = '0;
        wr_lane   = '0;
        free_rank = 0;
        lane_rank = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i]) begin
                lane_rank = 0;
                for (int l = 0; l < SS; l++) begin
                    if (iq.dispatch_valid[l]) begin
                        if (lane_rank == free_rank && disp_ready && !iq.flush) begin
                            wr_en[i]   = 1'b1;
                            wr_lane[i] = LANE_W'(l);
                        end
                        lane_rank++;
                    end
                end
                free_rank++;
            end
        end
    end

    // Per-port request vectors use registered ready bits only, so a wakeup
    // at edge C can issue at edge C+1 at the earliest.
    always_comb begin
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                req[f][i] = iq.fu_ready[f] && valid_q[i] && (int'(slot_q[i].fu_type) == f)
                            && slot_q[i].rdy1 && slot_q[i].rdy2;
            end
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
        iq_select #(.DEPTH(DEPTH)) u_sel (
            .req   (req[f]),
`ifdef IQ_AGE_SELECT_EN
            .older (older_q),
`endif
            .grant (grant[f])
        );
    end

    // Collect grants into the issue registers; flush suppresses the pulse.
    always_comb begin
        issued        = '0;
        issue_valid_d = '0;
        issue_entry_d = issue_entry_q;
        for (int f = 0; f < NUM_FU; f++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[f][i]) begin
                    issued[i]        = 1'b1;
                    issue_valid_d[f] = 1'b1;
                    issue_entry_d[f] = slot_q[i];
                end
            end
        end
        if (iq.flush) begin
            issue_valid_d = '0;
            issue_entry_d = issue_entry_q;
        end
    end

    // Slot next state: wakeup, issue release, dispatch write, flush.
    always_comb begin
        slot_d  = slot_q;
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                for (int k = 0; k < CDB_PORTS; k++) begin
                    if (iq.cdb_valid[k] && iq.cdb_preg[k] == slot_q[i].prs1) slot_d[i].rdy1 = 1'b1;
                    if (iq.cdb_valid[k] && iq.cdb_preg[k] == slot_q[i].prs2) slot_d[i].rdy2 = 1'b1;
                end
            end
            if (issued[i]) valid_d[i] = 1'b0;
            if (wr_en[i]) begin
                valid_d[i] = 1'b1;
                slot_d[i]  = disp_fixed[wr_lane[i]];
            end
        end
        if (iq.flush) valid_d = '0;
    end

`ifdef IQ_AGE_SELECT_EN
    // A new entry is older than nobody already queued; every slot not
    // written this cycle becomes older than it. Inside a bundle the lower
    // lane is the older one.
    always_comb begin
        older_d = older_q;
        for (int n = 0; n < DEPTH; n++) begin
            if (wr_en[n]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    older_d[n][j] = wr_en[j] && (wr_lane[j] > wr_lane[n]);
                end
                for (int j = 0; j < DEPTH; j++) begin
                    if (!wr_en[j]) older_d[j][n] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) older_q <= '0;
        else     older_q <= older_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= '0;
            slot_q        <= '0;
            issue_valid_q <= '0;
            issue_entry_q <= '0;
        end else begin
            valid_q       <= valid_d;
            slot_q        <= slot_d;
            issue_valid_q <= issue_valid_d;
            issue_entry_q <= issue_entry_d;
        end
    end

    // An accepted instruction must name an existing FU port.
    for (genvar l = 0; l < SS; l++) begin : g_fu_chk
        assert property (@(posedge clk) disable iff (rst)
            (iq.dispatch_valid[l] && disp_ready && !iq.flush)
                |-> (int'(iq.dispatch_entry[l].fu_type) < NUM_FU));
    end

endmodule
